// File: rtl/sseg_pkg.sv
// Shared constants and types for the seven-segment mux decoder.
// Holds the hex-to-segment table, the FSM state type and the one-hot digit enables.
package sseg_pkg;

   // Active-high segment patterns, bit order g..a.
   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;
   localparam logic [6:0] SEG_A = 7'h77;
   localparam logic [6:0] SEG_B = 7'h7C;
   localparam logic [6:0] SEG_C = 7'h39;
   localparam logic [6:0] SEG_D = 7'h5E;
   localparam logic [6:0] SEG_E = 7'h79;
   localparam logic [6:0] SEG_F = 7'h71;

   localparam logic [3:0] AN_DIG0 = 4'b0001;
   localparam logic [3:0] AN_DIG1 = 4'b0010;
   localparam logic [3:0] AN_DIG2 = 4'b0100;
   localparam logic [3:0] AN_DIG3 = 4'b1000;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      TRACK    = 2'd1,
      CAPTURED = 2'd2
   } state_t;

endpackage

// File: rtl/sseg_pattern_decode.sv
// Combinational inverse of the hex-to-segment table.
// legal is low for any pattern outside the 16-entry table.
module sseg_pattern_decode
   import sseg_pkg::*;
(
   input  logic [6:0] seg,
   output logic       legal,
   output logic [3:0] hex
);

   always_comb begin
      legal = 1'b1;
      hex   = '0;
      case (seg)
         SEG_0:   hex = 4'h0;
         SEG_1:   hex = 4'h1;
         SEG_2:   hex = 4'h2;
         SEG_3:   hex = 4'h3;
         SEG_4:   hex = 4'h4;
         SEG_5:   hex = 4'h5;
         SEG_6:   hex = 4'h6;
         SEG_7:   hex = 4'h7;
         SEG_8:   hex = 4'h8;
         SEG_9:   hex = 4'h9;
         SEG_A:   hex = 4'hA;
         SEG_B:   hex = 4'hB;
         SEG_C:   hex = 4'hC;
         SEG_D:   hex = 4'hD;
         SEG_E:   hex = 4'hE;
         SEG_F:   hex = 4'hF;
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/sseg_mux_decoder.sv
// Recovers four hex digits from a multiplexed seven-segment drive (an/sseg).
// Optional macro SSEG_DEC_CHANGE_IRQ_EN enables the change_pulse output.
module sseg_mux_decoder
   import sseg_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] an,
   input  logic [7:0] sseg,
   output logic [3:0] hex3,
   output logic [3:0] hex2,
   output logic [3:0] hex1,
   output logic [3:0] hex0,
   output logic [3:0] dp_out,
   output logic [3:0] digit_valid,
   output logic [3:0] seg_err,
   output logic       frame_done,
   output logic       change_pulse
);

   localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic [3:0] an_s1, an_s2, an_p;
   logic [7:0] sseg_s1, sseg_s2, sseg_p;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic capture;
   logic one_hot;
   logic [1:0] idx;
   logic changed;
   logic legal;
   logic [3:0] dec_hex;
   logic [3:0][3:0] hex_r;
   logic [3:0] mask_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an_s1   <= '0;
         an_s2   <= '0;
         an_p    <= '0;
         sseg_s1 <= '0;
         sseg_s2 <= '0;
         sseg_p  <= '0;
      end else begin
         an_s1   <= an;
         an_s2   <= an_s1;
         an_p    <= an_s2;
         sseg_s1 <= sseg;
         sseg_s2 <= sseg_s1;
         sseg_p  <= sseg_s2;
      end
   end

   always_comb begin
      one_hot = 1'b1;
      idx     = 2'd0;
      case (an_s2)
         AN_DIG0: idx = 2'd0;
         AN_DIG1: idx = 2'd1;
         AN_DIG2: idx = 2'd2;
         AN_DIG3: idx = 2'd3;
         default: one_hot = 1'b0;
      endcase
   end

   assign changed = (an_s2 != an_p) || (sseg_s2 != sseg_p);

   sseg_pattern_decode u_decode (
      .seg   (sseg_s2[6:0]),
      .legal (legal),
      .hex   (dec_hex)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Capture fires on the edge where the count would reach STABLE_CYCLES.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (one_hot) begin
               state_d = TRACK;
               cnt_d   = CNT_ONE;
            end
         end
         TRACK: begin
            if (!one_hot) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (changed) begin
               cnt_d = CNT_ONE;
            end else if (cnt_q >= CNT_MAX - CNT_ONE) begin
               capture = 1'b1;
               state_d = CAPTURED;
               cnt_d   = CNT_MAX;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         CAPTURED: begin
            if (!one_hot) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (changed) begin
               state_d = TRACK;
               cnt_d   = CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // A full mask is seen one cycle after the fourth capture, then cleared.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hex_r       <= '0;
         dp_out      <= '0;
         digit_valid <= '0;
         seg_err     <= '0;
         mask_q      <= '0;
         frame_done  <= 1'b0;
      end else begin
         if (capture) begin
            if (legal) hex_r[idx] <= dec_hex;
            dp_out[idx]      <= sseg_s2[7];
            digit_valid[idx] <= legal;
            seg_err[idx]     <= ~legal;
         end
         if (mask_q == 4'b1111) begin
            mask_q     <= '0;
            frame_done <= 1'b1;
         end else begin
            frame_done <= 1'b0;
            if (capture) mask_q <= mask_q | an_s2;
         end
      end
   end

   assign hex0 = hex_r[0];
   assign hex1 = hex_r[1];
   assign hex2 = hex_r[2];
   assign hex3 = hex_r[3];

`ifdef SSEG_DEC_CHANGE_IRQ_EN
   logic [3:0] new_hex;
   logic       differs;

   assign new_hex = legal ? dec_hex : hex_r[idx];
   assign differs = {new_hex, sseg_s2[7], legal} !=
                    {hex_r[idx], dp_out[idx], digit_valid[idx]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) change_pulse <= 1'b0;
      else       change_pulse <= capture && differs;
   end
`else
   assign change_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_sseg_mux_decoder.sv
// Self-checking bench for sseg_mux_decoder: table-driven dwells with a
// scoreboard queue, plus glitch, multi-hot and reset-mid-dwell sequences.
module tb_sseg_mux_decoder;

   localparam int unsigned SC = 16;

   typedef struct {
      logic [3:0]  an;
      logic [7:0]  sseg;
      int unsigned idx;
      logic [3:0]  hex;
      logic        dp;
      logic        valid;
      logic        err;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [3:0] an = '0;
   logic [7:0] sseg = '0;
   logic [3:0] hex3, hex2, hex1, hex0;
   logic [3:0] dp_out, digit_valid, seg_err;
   logic frame_done, change_pulse;

   int unsigned n_checks = 0;
   int unsigned n_fail = 0;
   int unsigned fd_cnt = 0;
   int unsigned cp_cnt = 0;

   vec_t vecs [9];
   vec_t sb [$];
   logic [3:0] m_hex [4];
   logic [3:0] m_dp, m_valid, m_err;

   sseg_mux_decoder #(.STABLE_CYCLES(SC)) dut (
      .clk          (clk),
      .reset        (reset),
      .an           (an),
      .sseg         (sseg),
      .hex3         (hex3),
      .hex2         (hex2),
      .hex1         (hex1),
      .hex0         (hex0),
      .dp_out       (dp_out),
      .digit_valid  (digit_valid),
      .seg_err      (seg_err),
      .frame_done   (frame_done),
      .change_pulse (change_pulse)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_done)   fd_cnt++;
      if (change_pulse) cp_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 4; i++) m_hex[i] = '0;
      m_dp = '0;
      m_valid = '0;
      m_err = '0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, "/hex0"}, {28'd0, hex0}, {28'd0, m_hex[0]});
      chk({tag, "/hex1"}, {28'd0, hex1}, {28'd0, m_hex[1]});
      chk({tag, "/hex2"}, {28'd0, hex2}, {28'd0, m_hex[2]});
      chk({tag, "/hex3"}, {28'd0, hex3}, {28'd0, m_hex[3]});
      chk({tag, "/dp_out"}, {28'd0, dp_out}, {28'd0, m_dp});
      chk({tag, "/digit_valid"}, {28'd0, digit_valid}, {28'd0, m_valid});
      chk({tag, "/seg_err"}, {28'd0, seg_err}, {28'd0, m_err});
   endtask

   // Called at a falling edge; returns at a falling edge about 20 cycles later.
   task automatic dwell(input vec_t v, input string tag);
      vec_t e;
      an = v.an;
      sseg = v.sseg;
      sb.push_back(v);
      repeat (SC + 1) @(posedge clk);
      @(negedge clk);
      check_all({tag, "/pre"});
      @(posedge clk);
      @(negedge clk);
      if (sb.size() == 0) begin
         chk({tag, "/sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         m_hex[e.idx]   = e.hex;
         m_dp[e.idx]    = e.dp;
         m_valid[e.idx] = e.valid;
         m_err[e.idx]   = e.err;
         check_all({tag, "/cap"});
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int unsigned fd0, cp0;
      vecs[0] = '{4'b0001, 8'h3F, 0, 4'h0, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{4'b0001, 8'h06, 0, 4'h1, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{4'b0010, 8'h5B, 1, 4'h2, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{4'b0100, 8'h4F, 2, 4'h3, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{4'b1000, 8'hE6, 3, 4'h4, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{4'b0100, 8'h49, 2, 4'h3, 1'b0, 1'b0, 1'b1};
      vecs[6] = '{4'b0010, 8'h66, 1, 4'h4, 1'b0, 1'b1, 1'b0};
      vecs[7] = '{4'b0001, 8'h3F, 0, 4'h0, 1'b0, 1'b1, 1'b0};
      vecs[8] = '{4'b0001, 8'h06, 0, 4'h1, 1'b0, 1'b1, 1'b0};
      model_clear();

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all("reset");
      chk("reset/frame_done", {31'd0, frame_done}, 32'd0);
      chk("reset/change_pulse", {31'd0, change_pulse}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      dwell(vecs[0], "digit0");

      fd0 = fd_cnt;
      for (int i = 1; i <= 4; i++) dwell(vecs[i], $sformatf("frame%0d", i));
      chk("frame/dp_out", {28'd0, dp_out}, 32'h8);
      chk("frame/frame_done_count", fd_cnt - fd0, 32'd1);

      dwell(vecs[5], "illegal");

      an = vecs[6].an;
      sseg = vecs[6].sseg;
      repeat (10) @(negedge clk);
      sseg = 8'h00;
      @(negedge clk);
      dwell(vecs[6], "glitch");

      fd0 = fd_cnt;
      an = 4'b0011;
      sseg = 8'h3F;
      repeat (40) @(negedge clk);
      check_all("multihot");
      chk("multihot/frame_done_count", fd_cnt - fd0, 32'd0);

      an = 4'b0001;
      sseg = 8'h7F;
      repeat (8) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      model_clear();
      check_all("reset_mid");
      chk("reset_mid/frame_done", {31'd0, frame_done}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      dwell('{4'b0001, 8'h7F, 0, 4'h8, 1'b0, 1'b1, 1'b0}, "after_reset");

      cp0 = cp_cnt;
      dwell(vecs[7], "chg_a");
      dwell(vecs[8], "chg_b");
      sseg = 8'h00;
      @(negedge clk);
      dwell(vecs[8], "chg_same");
`ifdef SSEG_DEC_CHANGE_IRQ_EN
      chk("change_pulse_count", cp_cnt - cp0, 32'd2);
`else
      chk("change_pulse_count", cp_cnt, 32'd0);
`endif
      chk("frame_done_total", fd_cnt, 32'd1);
      chk("scoreboard_drained", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
